// File: rtl/axicb_qos_arbiter_if.sv
// Request/grant bundle between the crossbar address-channel mux and its QoS arbiter.
// master drives requests, handshakes and completions; slave (the arbiter) returns grants.
interface axicb_qos_arbiter_if #(
    parameter int REQ_NB = 4
);
    logic [REQ_NB-1:0] req;
    logic              en;
    logic [REQ_NB-1:0] done;
    logic [REQ_NB-1:0] grant;
    logic              grant_valid;
    logic [REQ_NB-1:0] ostd_full;
    logic              timeout;

    modport master (
        output req, en, done,
        input  grant, grant_valid, ostd_full, timeout
    );

    modport slave (
        input  req, en, done,
        output grant, grant_valid, ostd_full, timeout
    );
endinterface

// File: rtl/axicb_qos_arbiter.sv
// Credit-based weighted round-robin arbiter with per-requester outstanding limit and grant timeout.
// Latency: req->grant 1 cycle; backpressure: grant held until en, req drop or timer expiry.
module axicb_qos_arbiter #(
    parameter int REQ_NB         = 4,
    parameter int WEIGHT_W       = 4,
    parameter int REQ0_WEIGHT    = 1,
    parameter int REQ1_WEIGHT    = 1,
    parameter int REQ2_WEIGHT    = 1,
    parameter int REQ3_WEIGHT    = 1,
    parameter int MAX_OSTD       = 8,
    parameter int TIMEOUT_ENABLE = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                srst,
    axicb_qos_arbiter_if.slave  bus
);

    localparam int OSTD_W = $clog2(MAX_OSTD + 1);
    localparam int PTR_W  = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_GRANT} state_t;

    state_t              state_q, state_d;
    logic [REQ_NB-1:0]   grant_q, grant_d;
    logic                grant_valid_q;
    logic                timeout_q, timeout_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [WEIGHT_W-1:0] credit_q [REQ_NB];
    logic [OSTD_W-1:0]   ostd_q   [REQ_NB];
    logic [OSTD_W-1:0]   ostd_d   [REQ_NB];
    logic [REQ_NB-1:0]   ostd_full_q;
    logic [REQ_NB-1:0]   open_req, eligible, take_vec;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_vld, take, refill;

    // A programmed weight of zero still earns one grant per round.
    function automatic logic [WEIGHT_W-1:0] weight_of(input int i);
        int w;
        case (i)
            0:       w = REQ0_WEIGHT;
            1:       w = REQ1_WEIGHT;
            2:       w = REQ2_WEIGHT;
            default: w = REQ3_WEIGHT;
        endcase
        if (w == 0) w = 1;
        return w[WEIGHT_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_NB - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < REQ_NB; i++) begin
            open_req[i] = bus.req[i] && (ostd_q[i] < OSTD_W'(MAX_OSTD));
            eligible[i] = open_req[i] && (credit_q[i] != '0);
        end
    end

    // Scan from the highest offset down so the entry nearest the pointer wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_v;
        idx      = 0;
        idx_v    = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = REQ_NB - 1; k >= 0; k--) begin
            idx   = (int'(ptr_q) + k) % REQ_NB;
            idx_v = idx[PTR_W-1:0];
            if (eligible[idx_v]) begin
                pick_vld = 1'b1;
                pick_idx = idx_v;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        timer_d   = '0;
        timeout_d = 1'b0;
        take      = 1'b0;
        refill    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    state_d           = S_GRANT;
                end else if (|open_req) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                refill  = 1'b1;
                state_d = S_IDLE;
            end
            S_GRANT: begin
                if (bus.en) begin
                    take    = 1'b1;
                    grant_d = '0;
                    ptr_d   = ptr_inc(gidx_q);
                    state_d = S_IDLE;
                end else if (!bus.req[gidx_q]) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (TIMEOUT_ENABLE != 0 && timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    ptr_d     = ptr_inc(gidx_q);
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            gidx_q        <= '0;
            timer_q       <= '0;
        end else if (srst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            gidx_q        <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            gidx_q        <= gidx_d;
            timer_q       <= timer_d;
        end
    end

    assign take_vec = take ? grant_q : '0;

    // An accept and a completion in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < REQ_NB; i++) begin
            ostd_d[i] = ostd_q[i];
            if (take_vec[i] && !bus.done[i]) begin
                ostd_d[i] = ostd_q[i] + 1'b1;
            end else if (!take_vec[i] && bus.done[i] && ostd_q[i] != '0) begin
                ostd_d[i] = ostd_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < REQ_NB; i++) begin
                credit_q[i]    <= weight_of(i);
                ostd_q[i]      <= '0;
                ostd_full_q[i] <= 1'b0;
            end
        end else if (srst) begin
            for (int i = 0; i < REQ_NB; i++) begin
                credit_q[i]    <= weight_of(i);
                ostd_q[i]      <= '0;
                ostd_full_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < REQ_NB; i++) begin
                if (refill) begin
                    credit_q[i] <= weight_of(i);
                end else if (take_vec[i]) begin
                    credit_q[i] <= credit_q[i] - 1'b1;
                end
                ostd_q[i]      <= ostd_d[i];
                ostd_full_q[i] <= (ostd_d[i] == OSTD_W'(MAX_OSTD));
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.ostd_full   = ostd_full_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_axicb_qos_arbiter.sv
// Directed bench: two arbiter instances (equal weights / skewed weights with small outstanding limit).
module tb_axicb_qos_arbiter;

    logic aclk = 1'b0;
    logic aresetn;
    logic srst;
    int   checks = 0;
    int   errors = 0;

    always #5 aclk = ~aclk;

    axicb_qos_arbiter_if #(.REQ_NB(4)) if_a ();
    axicb_qos_arbiter_if #(.REQ_NB(4)) if_b ();

    axicb_qos_arbiter #(
        .REQ_NB(4), .WEIGHT_W(4),
        .REQ0_WEIGHT(1), .REQ1_WEIGHT(1), .REQ2_WEIGHT(1), .REQ3_WEIGHT(1),
        .MAX_OSTD(8), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(16)
    ) u_a (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(if_a)
    );

    axicb_qos_arbiter #(
        .REQ_NB(4), .WEIGHT_W(4),
        .REQ0_WEIGHT(3), .REQ1_WEIGHT(1), .REQ2_WEIGHT(0), .REQ3_WEIGHT(0),
        .MAX_OSTD(2), .TIMEOUT_ENABLE(1), .TIMEOUT_CYCLES(16)
    ) u_b (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(if_b)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Accept the current grant, then complete it on the following cycle.
    task automatic b_txn(input logic [3:0] exp, input string tag);
        chk({tag, " grant"}, 32'(if_b.grant), 32'(exp));
        chk({tag, " valid"}, 32'(if_b.grant_valid), 32'd1);
        if_b.en = 1'b1;
        step();
        chk({tag, " clear"}, 32'(if_b.grant), 32'd0);
        if_b.en   = 1'b0;
        if_b.done = exp;
        step();
        if_b.done = 4'b0000;
    endtask

    task automatic a_txn(input logic [3:0] exp, input string tag);
        chk({tag, " grant"}, 32'(if_a.grant), 32'(exp));
        if_a.en = 1'b1;
        step();
        chk({tag, " clear"}, 32'(if_a.grant), 32'd0);
        if_a.en = 1'b0;
        step();
    endtask

    initial begin
        aresetn   = 1'b0;
        srst      = 1'b0;
        if_a.req  = 4'b0000;
        if_a.en   = 1'b0;
        if_a.done = 4'b0000;
        if_b.req  = 4'b0000;
        if_b.en   = 1'b0;
        if_b.done = 4'b0000;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst a grant", 32'(if_a.grant), 32'd0);
        chk("rst a valid", 32'(if_a.grant_valid), 32'd0);
        chk("rst a timeout", 32'(if_a.timeout), 32'd0);
        chk("rst a full", 32'(if_a.ostd_full), 32'd0);
        chk("rst b grant", 32'(if_b.grant), 32'd0);
        chk("rst b full", 32'(if_b.ostd_full), 32'd0);
        aresetn = 1'b1;
        step();

        // Weights 3,1,0,0: pointer advances past each winner, requester 0 still gets 3 per round.
        if_b.req = 4'b0011;
        step();
        b_txn(4'b0001, "t2 g1");
        b_txn(4'b0010, "t2 g2");
        b_txn(4'b0001, "t2 g3");
        b_txn(4'b0001, "t2 g4");
        chk("t2 refill", 32'(if_b.grant), 32'd0);
        step();
        chk("t2 idle", 32'(if_b.grant), 32'd0);
        step();
        b_txn(4'b0010, "t2 g5");
        if_b.req = 4'b1100;
        step();
        chk("t2 req drop", 32'(if_b.grant), 32'd0);
        step();
        b_txn(4'b0100, "t2 w0 g2");
        b_txn(4'b1000, "t2 w0 g3");
        chk("t2 w0 refill", 32'(if_b.grant), 32'd0);
        step();
        step();
        chk("t2 w0 wrap", 32'(if_b.grant), 32'd4);
        if_b.req = 4'b0000;
        step();
        chk("t2 drop2", 32'(if_b.grant), 32'd0);

        // Outstanding limit of 2 on requester 0.
        if_b.req = 4'b0001;
        step();
        chk("t3 g1", 32'(if_b.grant), 32'd1);
        if_b.en = 1'b1;
        step();
        chk("t3 full0", 32'(if_b.ostd_full), 32'd0);
        if_b.en = 1'b0;
        step();
        chk("t3 g2", 32'(if_b.grant), 32'd1);
        if_b.en = 1'b1;
        step();
        chk("t3 full1", 32'(if_b.ostd_full), 32'd1);
        if_b.en = 1'b0;
        step();
        chk("t3 skip1", 32'(if_b.grant), 32'd0);
        step();
        chk("t3 skip2", 32'(if_b.grant), 32'd0);
        if_b.done = 4'b0001;
        step();
        if_b.done = 4'b0000;
        chk("t3 full2", 32'(if_b.ostd_full), 32'd0);
        chk("t3 nogrant", 32'(if_b.grant), 32'd0);
        step();
        chk("t3 regrant", 32'(if_b.grant), 32'd1);

        // Same-cycle en and done keep outstanding at 1; extra done on zero is ignored.
        if_b.en   = 1'b1;
        if_b.done = 4'b0001;
        step();
        if_b.en   = 1'b0;
        if_b.done = 4'b0000;
        chk("t5 net0 clear", 32'(if_b.grant), 32'd0);
        chk("t5 net0 full", 32'(if_b.ostd_full), 32'd0);
        step();
        chk("t5 refill", 32'(if_b.grant), 32'd0);
        step();
        chk("t5 idle", 32'(if_b.grant), 32'd0);
        step();
        chk("t5 g", 32'(if_b.grant), 32'd1);
        if_b.en = 1'b1;
        step();
        chk("t5 full at 2", 32'(if_b.ostd_full), 32'd1);
        if_b.en   = 1'b0;
        if_b.req  = 4'b0000;
        if_b.done = 4'b0001;
        repeat (3) step();
        if_b.done = 4'b0000;
        chk("t5 drained", 32'(if_b.ostd_full), 32'd0);
        if_b.req = 4'b0001;
        step();
        chk("t5 zero g1", 32'(if_b.grant), 32'd1);
        if_b.en = 1'b1;
        step();
        if_b.en = 1'b0;
        step();
        chk("t5 zero g2", 32'(if_b.grant), 32'd1);
        if_b.en = 1'b1;
        step();
        chk("t5 zero full", 32'(if_b.ostd_full), 32'd1);
        if_b.en  = 1'b0;
        if_b.req = 4'b0000;

        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("srst b full", 32'(if_b.ostd_full), 32'd0);
        chk("srst b grant", 32'(if_b.grant), 32'd0);
        chk("srst a grant", 32'(if_a.grant), 32'd0);

        // Equal weights: plain rotation, refill after the last requester.
        if_a.req = 4'b1111;
        step();
        a_txn(4'b0001, "t1 g0");
        a_txn(4'b0010, "t1 g1");
        a_txn(4'b0100, "t1 g2");
        a_txn(4'b1000, "t1 g3");
        chk("t1 refill", 32'(if_a.grant), 32'd0);
        step();
        chk("t1 idle", 32'(if_a.grant), 32'd0);
        step();
        chk("t1 wrap", 32'(if_a.grant), 32'd1);
        if_a.req = 4'b0000;
        step();
        chk("t1 req drop", 32'(if_a.grant), 32'd0);

        // Grant held 16 cycles without en is revoked.
        if_a.req = 4'b0011;
        step();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4 hold %0d", i), 32'(if_a.grant), 32'd1);
            chk($sformatf("t4 tmo %0d", i), 32'(if_a.timeout), 32'd0);
            step();
        end
        chk("t4 revoked", 32'(if_a.grant), 32'd0);
        chk("t4 pulse", 32'(if_a.timeout), 32'd1);
        step();
        chk("t4 pulse end", 32'(if_a.timeout), 32'd0);
        a_txn(4'b0010, "t4 next");
        chk("t4 credit kept", 32'(if_a.grant), 32'd1);
        if_a.en = 1'b1;
        step();
        if_a.en  = 1'b0;
        if_a.req = 4'b0100;
        step();
        chk("t6 pre", 32'(if_a.grant), 32'd4);

        // Async reset in the middle of a held grant.
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6 async grant", 32'(if_a.grant), 32'd0);
        chk("t6 async valid", 32'(if_a.grant_valid), 32'd0);
        @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        if_a.req = 4'b1100;
        step();
        chk("t6 ptr0", 32'(if_a.grant), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
